// File: rtl/handshake_gen_pkg.sv
// Shared types and constants for the handshake_gen AXI-Stream traffic source.
package handshake_gen_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Galois form of x^64+x^63+x^61+x^60+1, shifting towards bit 0
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_SEED = 64'h0000_0000_0000_0001;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/hs_pattern_gen.sv
// Payload generator: incrementing beat index or 64-bit Galois LFSR.
module hs_pattern_gen
  import handshake_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  input  logic        mode,
  output logic [63:0] data
);

  logic [63:0] index_reg;
  logic [63:0] lfsr_reg;
  logic        mode_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_reg <= '0;
      lfsr_reg  <= LFSR_SEED;
      mode_reg  <= 1'b0;
    end else if (load) begin
      index_reg <= '0;
      lfsr_reg  <= LFSR_SEED;
      mode_reg  <= mode;
    end else if (advance) begin
      index_reg <= index_reg + 64'd1;
      lfsr_reg  <= lfsr_step(lfsr_reg);
    end
  end

  assign data = mode_reg ? lfsr_reg : index_reg;

endmodule

// File: rtl/handshake_gen.sv
// AXI-Stream traffic source: sends a programmed number of beats with optional
// idle gaps, honours backpressure and keeps send-side statistics.
module handshake_gen #(
  parameter int DATA_W = handshake_gen_pkg::DATA_W,
  parameter int CNT_W  = handshake_gen_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  pkt_limit,
  input  logic [7:0]        gap,
  input  logic              mode,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
);

  import handshake_gen_pkg::*;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   limit_reg;
  logic [7:0]         gap_reg;
  logic [7:0]         gap_cnt_reg;
  logic [CNT_W-1:0]   sent_cnt_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [CNT_W-1:0]   cycle_cnt_reg;
  logic [63:0]        pat_data;

  logic start_ok;
  logic hs;
  logic last_beat;

  // A start arriving alongside the final handshake sees SEND and is dropped
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign hs        = (state_reg == SEND) && m_axis_tready;
  assign last_beat = (sent_cnt_reg == (limit_reg - 1'b1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_ok) state_next = (pkt_limit == '0) ? DONE : SEND;
      end
      SEND: begin
        if (hs) begin
          if (last_beat)         state_next = DONE;
          else if (gap_reg != 0) state_next = GAP;
          else                   state_next = SEND;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 8'd1) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      limit_reg     <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      sent_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        limit_reg     <= pkt_limit;
        gap_reg       <= gap;
        gap_cnt_reg   <= '0;
        sent_cnt_reg  <= '0;
        stall_cnt_reg <= '0;
        cycle_cnt_reg <= '0;
      end else begin
        if (hs && !last_beat)
          gap_cnt_reg <= gap_reg;
        else if (state_reg == GAP)
          gap_cnt_reg <= gap_cnt_reg - 8'd1;

        // Statistics saturate at all-ones rather than wrapping
        if (hs && (sent_cnt_reg != '1))
          sent_cnt_reg <= sent_cnt_reg + 1'b1;
        if ((state_reg == SEND) && !m_axis_tready && (stall_cnt_reg != '1))
          stall_cnt_reg <= stall_cnt_reg + 1'b1;
        if (((state_reg == SEND) || (state_reg == GAP)) && (cycle_cnt_reg != '1))
          cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      end
    end
  end

  hs_pattern_gen u_pattern (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .advance (hs),
    .mode    (mode),
    .data    (pat_data)
  );

  assign m_axis_tvalid = (state_reg == SEND);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tdata  = pat_data[DATA_W-1:0];
  assign busy          = (state_reg == SEND) || (state_reg == GAP);
  assign done          = (state_reg == DONE);
  assign sent_cnt      = sent_cnt_reg;
  assign stall_cnt     = stall_cnt_reg;
  assign cycle_cnt     = cycle_cnt_reg;

endmodule

// File: tb/tb_handshake_gen.sv
// Self-checking bench for handshake_gen: scoreboard of expected beats plus
// per-scenario checks of counters, gaps, backpressure and reset.
module tb_handshake_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pkt_limit = '0;
  logic [7:0]  gap = '0;
  logic        mode = 1'b0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [63:0] tdata;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [31:0] sent_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] cycle_cnt;

  handshake_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .pkt_limit     (pkt_limit),
    .gap           (gap),
    .mode          (mode),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .done          (done),
    .sent_cnt      (sent_cnt),
    .stall_cnt     (stall_cnt),
    .cycle_cnt     (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_q[$];
  int    test_cnt = 0;
  int    fail_cnt = 0;
  int    cyc = 0;

  beat_t       mon_e;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(posedge clk) cyc++;

  // Scoreboard: every completed handshake pops one expected beat
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        test_cnt++;
        if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
          fail_cnt++;
          $display("FAIL axi_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        test_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL unexpected_beat: tdata=%h tlast=%b, required no beat", tdata, tlast);
        end else begin
          mon_e = exp_q.pop_front();
          if (tdata !== mon_e.data || tlast !== mon_e.last) begin
            fail_cnt++;
            $display("FAIL beat: tdata=%h tlast=%b, required %h %b",
                     tdata, tlast, mon_e.data, mon_e.last);
          end else begin
            $display("[TB] beat tdata=%h tlast=%b at cycle %0d", tdata, tlast, cyc);
          end
        end
        hs_q.push_back(cyc);
      end
      prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic launch(input int lim, input int g, input logic m);
    @(posedge clk); #1;
    pkt_limit = lim;
    gap       = g;
    mode      = m;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_incr(input int lim);
    beat_t b;
    for (int i = 0; i < lim; i++) begin
      b.data = 64'(i);
      b.last = (i == lim - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    test_cnt++;
    if ({tvalid, tlast, busy, done} !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL reset_flags: tvalid/tlast/busy/done=%b, required 0000", {tvalid, tlast, busy, done});
    end
    test_cnt++;
    if (sent_cnt !== 0 || stall_cnt !== 0 || cycle_cnt !== 0 || tdata !== 64'd0) begin
      fail_cnt++;
      $display("FAIL reset_counters: sent=%0d stall=%0d cycle=%0d tdata=%h, required all 0",
               sent_cnt, stall_cnt, cycle_cnt, tdata);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_incr();
    tready = 1'b1;
    hs_q.delete();
    push_incr(4);
    launch(4, 0, 1'b0);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL incr_done: done=%b, required 1", done);
    end
    test_cnt++;
    if (hs_q.size() != 4 || (hs_q[3] - hs_q[0]) != 3) begin
      fail_cnt++;
      $display("FAIL incr_spacing: %0d beats span %0d cycles, required 4 beats span 3",
               hs_q.size(), hs_q.size() > 0 ? hs_q[hs_q.size()-1] - hs_q[0] : -1);
    end
    test_cnt++;
    if (cycle_cnt !== 4 || stall_cnt !== 0 || sent_cnt !== 4 || busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL incr_stats: cycle=%0d stall=%0d sent=%0d busy=%b, required 4 0 4 0",
               cycle_cnt, stall_cnt, sent_cnt, busy);
    end
    test_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL incr_pending: %0d beats left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_gap();
    tready = 1'b1;
    hs_q.delete();
    push_incr(3);
    launch(3, 2, 1'b0);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (hs_q.size() != 3 || (hs_q[1] - hs_q[0]) != 3 || (hs_q[2] - hs_q[1]) != 3) begin
      fail_cnt++;
      $display("FAIL gap_spacing: %0d beats, spacing %0d/%0d, required 3 beats spacing 3/3",
               hs_q.size(), hs_q.size() > 1 ? hs_q[1] - hs_q[0] : -1,
               hs_q.size() > 2 ? hs_q[2] - hs_q[1] : -1);
    end
    test_cnt++;
    if (cycle_cnt !== 7 || sent_cnt !== 3 || done !== 1'b1) begin
      fail_cnt++;
      $display("FAIL gap_stats: cycle=%0d sent=%0d done=%b, required 7 3 1", cycle_cnt, sent_cnt, done);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int held_bad = 0;
    tready = 1'b0;
    push_incr(2);
    launch(2, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tvalid !== 1'b1 || tdata !== 64'd0) held_bad++;
      @(posedge clk); #1;
    end
    test_cnt++;
    if (held_bad != 0) begin
      fail_cnt++;
      $display("FAIL stall_hold: %0d stall cycles without tvalid=1 tdata=0, required 0", held_bad);
    end
    tready = 1'b1;
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (stall_cnt !== 5 || sent_cnt !== 2 || cycle_cnt !== 7) begin
      fail_cnt++;
      $display("FAIL stall_stats: stall=%0d sent=%0d cycle=%0d, required 5 2 7",
               stall_cnt, sent_cnt, cycle_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_lfsr();
    beat_t       b;
    logic [63:0] s = 64'h1;
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.data = s;
      b.last = (i == 3);
      exp_q.push_back(b);
      s = s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    end
    launch(4, 0, 1'b1);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (sent_cnt !== 4 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL lfsr_run: sent=%0d pending=%0d, required 4 0", sent_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero_limit();
    int valid_seen = 0;
    launch(0, 0, 1'b0);
    @(negedge clk);
    test_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || sent_cnt !== 0 || stall_cnt !== 0 || cycle_cnt !== 0) begin
      fail_cnt++;
      $display("FAIL zero_limit: done=%b busy=%b sent=%0d stall=%0d cycle=%0d, required 1 0 0 0 0",
               done, busy, sent_cnt, stall_cnt, cycle_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      if (tvalid !== 1'b0) valid_seen++;
      @(negedge clk);
    end
    test_cnt++;
    if (valid_seen != 0) begin
      fail_cnt++;
      $display("FAIL zero_limit_valid: tvalid high %0d cycles, required 0", valid_seen);
    end
  endtask

  task automatic test_back_to_back();
    tready = 1'b1;
    hs_q.delete();
    push_incr(4);
    launch(4, 1, 1'b0);
    // Start while busy must be ignored
    pkt_limit = 1; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !(tvalid === 1'b1 && tlast === 1'b1); i++) @(negedge clk);
    // Start coinciding with the final handshake must also be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    test_cnt++;
    if (done !== 1'b1 || sent_cnt !== 4 || tvalid !== 1'b0 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL start_ignored: done=%b sent=%0d tvalid=%b pending=%0d, required 1 4 0 0",
               done, sent_cnt, tvalid, exp_q.size());
    end
    exp_q.delete();
    push_incr(2);
    launch(2, 0, 1'b0);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (done !== 1'b1 || sent_cnt !== 2 || cycle_cnt !== 2 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL back_to_back: done=%b sent=%0d cycle=%0d pending=%0d, required 1 2 2 0",
               done, sent_cnt, cycle_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    tready = 1'b1;
    push_incr(10);
    launch(10, 0, 1'b0);
    for (int i = 0; i < 100 && sent_cnt !== 5; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    test_cnt++;
    if ({tvalid, tlast, busy, done} !== 4'b0000 || sent_cnt !== 0 || stall_cnt !== 0 ||
        cycle_cnt !== 0 || tdata !== 64'd0) begin
      fail_cnt++;
      $display("FAIL async_reset: flags=%b sent=%0d stall=%0d cycle=%0d tdata=%h, required all 0",
               {tvalid, tlast, busy, done}, sent_cnt, stall_cnt, cycle_cnt, tdata);
    end
    exp_q.delete();
    @(posedge clk);
    #3 reset_n = 1'b1;
    push_incr(3);
    launch(3, 0, 1'b0);
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    test_cnt++;
    if (done !== 1'b1 || sent_cnt !== 3 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL post_reset_run: done=%b sent=%0d pending=%0d, required 1 3 0",
               done, sent_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_gap();
    test_backpressure();
    test_lfsr();
    test_zero_limit();
    test_back_to_back();
    test_reset_midrun();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
